nmr_echo_acq: RTL
=================

# nmr_echo_acq

Echo acquisition sequencer between the ADC front-end and the ADC sample FIFO sink of the SoC system (16-bit Avalon-ST data/valid/ready). It gates raw ADC samples into per-echo windows, counting samples_per_echo samples for each of echoes_per_scan echoes. It converts offset-binary samples to sign-extended two's complement and buffers them through a small skid FIFO so sink back-pressure does not stall capture. Capture stalls are reported by a sticky overflow flag.

## Interface
- ADC_W, 14, ADC sample width, 8..16
- FIFO_DEPTH, 8, skid FIFO entries, power of two, >= 2
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous, active-low reset
- adc_data  in  ADC_W  offset-binary ADC sample
- adc_valid  in  1  adc_data valid this cycle
- scan_start  in  1  one-cycle pulse; arms a scan
- acq_trig  in  1  one-cycle pulse; opens one echo window
- abort  in  1  level; forces IDLE and flushes FIFO
- samples_per_echo  in  32  latched at scan_start
- echoes_per_scan  in  32  latched at scan_start
- out_data  out  16  Avalon-ST data to the ADC FIFO sink
- out_valid  out  1  Avalon-ST valid
- out_ready  in  1  Avalon-ST ready from the sink
- busy  out  1  state != IDLE
- scan_done  out  1  one-cycle pulse at end of scan
- overflow  out  1  sticky; sample dropped due to full FIFO
- echo_cnt  out  32  echoes completed in the current or last scan

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - On scan_start, latch spe=samples_per_echo and eps=echoes_per_scan, clear echo_cnt and overflow.
  - Go to DONE if eps==0, else ARMED.
- ARMED:
  - On acq_trig, clear sample counter.
  - Go to CAPTURE, or straight to echo-complete handling if spe==0.
- CAPTURE:
  - Each cycle with adc_valid, increment the sample counter and push the converted sample if the FIFO has space.
  - If the FIFO is full, drop the sample, still count it, and set overflow.
  - When the counter reaches spe, increment echo_cnt. Go to DONE if echo_cnt+1==eps, else ARMED.
- DONE: assert scan_done for exactly one cycle, then go to IDLE.
- Ignored inputs:
  - acq_trig outside ARMED.
  - scan_start outside IDLE.
- abort:
  - Any state goes to IDLE next cycle and the FIFO is emptied.
  - echo_cnt and overflow are held; no scan_done.
  - abort overrides all other inputs in the same cycle.
- Conversion:
  - Invert adc_data[ADC_W-1], then sign-extend to 16 bits.
  - Example: ADC_W=14, 0x2000 gives 0x0000; 0x0000 gives 0xE000; 0x3FFF gives 0x1FFF.
- FIFO push/pop:
  - A push is accepted when not full, or when full and a pop occurs the same cycle.
  - Pop occurs when out_valid && out_ready.
- Counters are 32-bit unsigned; no wrap handling is required beyond modulo-2^32.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, scan_done=0, overflow=0, echo_cnt=0, state IDLE, FIFO empty.
- scan_start sampled at edge T: busy=1 from T+1.
- acq_trig sampled at edge T in ARMED: the first eligible sample is at edge T+1.
- Sample-to-output latency: a sample accepted at edge N with an empty FIFO gives out_valid=1 with that data after edge N+1.
- Avalon-ST rules:
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - out_valid does not depend combinationally on out_ready.
- Last sample of the last echo accepted at edge N: echo_cnt updates and state=DONE after N; scan_done=1 during cycle N+1; busy=0 after edge N+2.
- scan_done does not wait for FIFO drain; the FIFO keeps draining in IDLE.
- With out_ready held high, sustained throughput is 1 sample/cycle with no drops.
- Asynchronous reset mid-capture clears everything immediately; the partial echo is lost.

## Test plan
- Basic scan: ADC_W=14, spe=4, eps=2, out_ready=1, adc_valid=1, data 0x2000..0x2003 -> out_data 0x0000..0x0003 twice, echo_cnt=2, one scan_done pulse, overflow=0.
- Back-pressure: spe=16, eps=1, out_ready=0 for 20 cycles then 1 -> exactly 8 words (first 8 samples) emitted in order, overflow=1, scan_done still pulses, echo_cnt=1.
- Zero config:
  - eps=0 -> scan_done 2 cycles after scan_start, no output.
  - spe=0, eps=3 with 3 acq_trig pulses -> echo_cnt=3, no output, scan_done.
- Trigger filtering: acq_trig during CAPTURE and in IDLE, and scan_start during ARMED -> no extra samples, config unchanged, echo_cnt counts only valid windows.
- Abort/reset: abort after 2 of 4 samples with 2 words in FIFO, out_ready=0 -> out_valid=0 next cycle, busy=0, no scan_done, echo_cnt=0. Repeat using reset_reset_n low mid-capture -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/nmr_echo_acq.sv
// nmr_echo_acq
// Echo acquisition sequencer. It arms on scan_start, opens one sample window
// per acq_trig, and counts samples_per_echo samples for each of
// echoes_per_scan echoes. Each accepted sample is converted from offset
// binary to sign-extended two's complement. The sample then passes through
// a small skid FIFO into an Avalon-ST source, so sink back-pressure does not
// stall capture. When a sample arrives while the FIFO is full, the sample is
// dropped, still counted, and the sticky overflow flag is set.
//
// Ports
//   clk_clk, reset_reset_n            clock, asynchronous active-low reset
//   adc_data, adc_valid               offset-binary ADC sample stream
//   scan_start, acq_trig              one-cycle pulses: arm scan, open window
//   abort                             level: return to IDLE, flush FIFO
//   samples_per_echo, echoes_per_scan scan configuration, latched at scan_start
//   out_data, out_valid, out_ready    Avalon-ST source to the ADC sample FIFO
//   busy, scan_done, overflow         status: not idle, end-of-scan pulse, sticky drop
//   echo_cnt                          echoes completed in current/last scan
module nmr_echo_acq #(
  parameter int ADC_W      = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic             scan_start,
  input  logic             acq_trig,
  input  logic             abort,
  input  logic [31:0]      samples_per_echo,
  input  logic [31:0]      echoes_per_scan,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             scan_done,
  output logic             overflow,
  output logic [31:0]      echo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      spe;
  logic [31:0]      eps;
  logic [31:0]      smp_cnt;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      fill;
  logic [AW:0]      fill_after_pop;
  logic [AW:0]      rd_next;
  logic             full;
  logic             pop;
  logic             take;
  logic             push;
  logic             drop;
  logic             last_smp;
  logic             echo_last;

  logic [ADC_W-1:0] flipped;
  logic [15:0]      conv;

  // Flipping the MSB turns offset binary into two's complement of the same width.
  always_comb begin
    flipped = adc_data ^ (ADC_W'(1) << (ADC_W - 1));
    conv    = 16'($signed(flipped));
  end

  assign fill           = wr_ptr - rd_ptr;
  assign full           = (fill == (AW + 1)'(FIFO_DEPTH));
  assign pop            = out_valid && out_ready;
  assign take           = (state == CAPTURE) && adc_valid && !abort;
  assign push           = take && (!full || pop);
  assign drop           = take && full && !pop;
  assign last_smp       = (smp_cnt + 32'd1 == spe);
  assign echo_last      = (echo_cnt + 32'd1 == eps);
  assign fill_after_pop = fill - (AW + 1)'(pop);
  assign rd_next        = rd_ptr + (AW + 1)'(pop);
  assign busy           = (state != IDLE);

  // Scan sequencer
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      spe       <= '0;
      eps       <= '0;
      smp_cnt   <= '0;
      echo_cnt  <= '0;
      overflow  <= 1'b0;
      scan_done <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      scan_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            spe      <= samples_per_echo;
            eps      <= echoes_per_scan;
            echo_cnt <= '0;
            overflow <= 1'b0;
            state    <= (echoes_per_scan == '0) ? DONE : ARMED;
          end
        end
        ARMED: begin
          if (acq_trig) begin
            smp_cnt <= '0;
            // An empty window completes the echo without visiting CAPTURE.
            if (spe == '0) begin
              echo_cnt <= echo_cnt + 32'd1;
              state    <= echo_last ? DONE : ARMED;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (adc_valid) begin
            smp_cnt <= smp_cnt + 32'd1;
            if (drop) begin
              overflow <= 1'b1;
            end
            if (last_smp) begin
              echo_cnt <= echo_cnt + 32'd1;
              state    <= echo_last ? DONE : ARMED;
            end
          end
        end
        DONE: begin
          // The first DONE cycle raises the pulse. The second cycle drops it and leaves.
          if (!scan_done) begin
            scan_done <= 1'b1;
          end else begin
            scan_done <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Skid FIFO storage
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= conv;
    end
  end

  // The output register always presents the FIFO head, which stays stored
  // until it is popped. A word pushed at an edge becomes visible one edge
  // later. That keeps the output a pure register, with no combinational path
  // from out_ready. It also keeps data stable while the sink stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      rd_ptr    <= rd_next;
      out_valid <= (fill_after_pop != '0);
      if (fill_after_pop != '0) begin
        out_data <= mem[rd_next[AW-1:0]];
      end
    end
  end

endmodule
